// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 key-schedule controller slice.
//   NUM_ROUNDS / NUM_RKEYS : expansion rounds and number of stored round keys
//   RK_ADDR_W / KEY_W      : round-key index width and key word width
//   ks_state_t             : controller FSM state encoding
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;
    localparam int unsigned NUM_RKEYS  = 11;
    localparam int unsigned RK_ADDR_W  = 4;
    localparam int unsigned KEY_W      = 128;

    typedef logic [KEY_W-1:0]     key_t;
    typedef logic [RK_ADDR_W-1:0] rk_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } ks_state_t;

endpackage

// File: rtl/aes_key_schedule_ctrl_if.sv
// Handshake and round-key read bus between the encryption controller (master)
// and the key-schedule controller (slave).
//   start, key_in        : expansion request and cipher key
//   busy, done           : expansion in progress / one-cycle completion pulse
//   keys_valid           : key store holds a complete schedule
//   rk_rd_addr/rk_rd_data: combinational round-key read port
interface aes_key_schedule_ctrl_if;
    import aes_pkg::*;

    logic     start;
    key_t     key_in;
    logic     busy;
    logic     done;
    logic     keys_valid;
    rk_addr_t rk_rd_addr;
    key_t     rk_rd_data;

    modport master (
        output start,
        output key_in,
        output rk_rd_addr,
        input  busy,
        input  done,
        input  keys_valid,
        input  rk_rd_data
    );

    modport slave (
        input  start,
        input  key_in,
        input  rk_rd_addr,
        output busy,
        output done,
        output keys_valid,
        output rk_rd_data
    );

endinterface

// File: rtl/aes_rk_store.sv
// Round-key register file: NUM_RKEYS entries of KEY_W bits.
//   clk, rst_n : clock, asynchronous active-low clear of every entry
//   wr_en, wr_addr, wr_data : single write port (out-of-range writes dropped)
//   rd_addr, rd_data        : combinational read, zero for out-of-range index
module aes_rk_store
    import aes_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     wr_en,
    input  rk_addr_t wr_addr,
    input  key_t     wr_data,
    input  rk_addr_t rd_addr,
    output key_t     rd_data
);

    localparam rk_addr_t LAST_ADDR = rk_addr_t'(NUM_RKEYS - 1);

    key_t mem [NUM_RKEYS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else if (wr_en && (wr_addr <= LAST_ADDR)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_addr <= LAST_ADDR) begin
            rd_data = mem[rd_addr];
        end
    end

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule controller. Steps an external single-round key
// expansion datapath through NUM_ROUNDS rounds and keeps round keys 0..10.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus (slave)       : start/key_in request, busy/done/keys_valid status,
//                       rk_rd_addr/rk_rd_data combinational round-key read
//   kg_key, kg_rc     : previous round key and round-constant index to datapath
//   kg_keyout         : next round key from datapath, valid SBOX_LAT cycles
//                       after kg_key/kg_rc become stable
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned SBOX_LAT   = 1,
    parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    aes_key_schedule_ctrl_if.slave   bus,
    output logic [aes_pkg::KEY_W-1:0] kg_key,
    output logic [3:0]               kg_rc,
    input  logic [aes_pkg::KEY_W-1:0] kg_keyout
);

    localparam logic [2:0] WCNT_INIT = 3'(SBOX_LAT);
    localparam logic [3:0] RC_LAST   = 4'(NUM_ROUNDS - 1);

    ks_state_t  state;
    logic [2:0] wcnt;
    logic       busy_q;
    logic       done_q;
    logic       kv_q;

    logic       capture;
    logic       st_wr_en;
    rk_addr_t   st_wr_addr;
    key_t       st_wr_data;
    key_t       st_rd_data;

    // The datapath output is sampled on the edge where the wait counter has
    // already run down; kg_key/kg_rc stay put until then.
    assign capture = (state == ROUND) && (wcnt == '0);

    // kg_key doubles as the current-key register, kg_rc as the round counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wcnt   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            kv_q   <= 1'b0;
            kg_key <= '0;
            kg_rc  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        kg_key <= bus.key_in;
                        kg_rc  <= '0;
                        wcnt   <= WCNT_INIT;
                        kv_q   <= 1'b0;
                        busy_q <= 1'b1;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - 3'd1;
                    end else begin
                        kg_key <= kg_keyout;
                        if (kg_rc == RC_LAST) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            kg_rc <= kg_rc + 4'd1;
                            wcnt  <= WCNT_INIT;
                        end
                    end
                end
                DONE: begin
                    kv_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Entry 0 is written with the cipher key on the accept edge; entry rc+1
    // takes each expansion result.
    always_comb begin
        st_wr_en   = 1'b0;
        st_wr_addr = '0;
        st_wr_data = '0;
        if ((state == IDLE) && bus.start) begin
            st_wr_en   = 1'b1;
            st_wr_data = bus.key_in;
        end else if (capture) begin
            st_wr_en   = 1'b1;
            st_wr_addr = kg_rc + 4'd1;
            st_wr_data = kg_keyout;
        end
    end

    aes_rk_store u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (st_wr_en),
        .wr_addr (st_wr_addr),
        .wr_data (st_wr_data),
        .rd_addr (bus.rk_rd_addr),
        .rd_data (st_rd_data)
    );

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.keys_valid = kv_q;
    assign bus.rk_rd_data = st_rd_data;

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Self-checking bench for aes_key_schedule_ctrl: three controllers built with
// SBOX_LAT = 1, 0 and 3, each driving its own behavioural key-expansion model
// with the matching latency, all fed by the same start/key_in/rd_addr.
module tb_aes_key_schedule_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sb(input logic [7:0] v);
        return SBOX[(255 - int'(v)) * 8 +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rc);
        case (rc)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] expand(input logic [127:0] k, input logic [3:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
        t  = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])} ^ {rcon(rc), 24'h0};
        n0 = w0 ^ t; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic [3:0]   rd_addr;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] exp_rk [11];

    always #5 clk = ~clk;

    aes_key_schedule_ctrl_if ifa ();
    aes_key_schedule_ctrl_if ifb ();
    aes_key_schedule_ctrl_if ifc ();

    assign ifa.start = start;  assign ifa.key_in = key_in;  assign ifa.rk_rd_addr = rd_addr;
    assign ifb.start = start;  assign ifb.key_in = key_in;  assign ifb.rk_rd_addr = rd_addr;
    assign ifc.start = start;  assign ifc.key_in = key_in;  assign ifc.rk_rd_addr = rd_addr;

    logic [127:0] ka_key, ka_out, kb_key, kb_out, kc_key, kc_out;
    logic [3:0]   ka_rc, kb_rc, kc_rc;
    logic [127:0] fa, fc, dc1, dc2;

    // Expansion models: latency 1, 0 and 3 cycles after kg_key/kg_rc settle.
    assign fa     = expand(ka_key, ka_rc);
    assign kb_out = expand(kb_key, kb_rc);
    assign fc     = expand(kc_key, kc_rc);
    always @(posedge clk) begin
        ka_out <= fa;
        dc1    <= fc;
        dc2    <= dc1;
        kc_out <= dc2;
    end

    aes_key_schedule_ctrl #(.SBOX_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa),
        .kg_key(ka_key), .kg_rc(ka_rc), .kg_keyout(ka_out));
    aes_key_schedule_ctrl #(.SBOX_LAT(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb),
        .kg_key(kb_key), .kg_rc(kb_rc), .kg_keyout(kb_out));
    aes_key_schedule_ctrl #(.SBOX_LAT(3)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(ifc),
        .kg_key(kc_key), .kg_rc(kc_rc), .kg_keyout(kc_out));

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic build_model(input logic [127:0] k);
        exp_rk[0] = k;
        for (int r = 0; r < 10; r++) exp_rk[r+1] = expand(exp_rk[r], 4'(r));
    endtask

    function automatic logic [127:0] rd_of(input int inst);
        case (inst)
            0: return ifa.rk_rd_data;
            1: return ifb.rk_rd_data;
            default: return ifc.rk_rd_data;
        endcase
    endfunction

    // Starts a request on the next edge and counts sampled cycles until done
    // on instance a; -1 if the budget runs out.
    task automatic run_a(input logic [127:0] k, output int done_k);
        done_k = -1;
        @(negedge clk); start = 1'b1; key_in = k;
        @(posedge clk);
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (ifa.done && done_k < 0) done_k = c;
        end
    endtask

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
        string        name;
    } rd_vec_t;

    rd_vec_t vec [7];

    initial begin
        int done_a, done_b, done_c, ndone_a, busy_a, rc_bad, kv_bad, k;

        vec[0] = '{4'd0,  FIPS_KEY,  "rk0_key"};
        vec[1] = '{4'd1,  FIPS_RK1,  "rk1"};
        vec[2] = '{4'd10, FIPS_RK10, "rk10"};
        vec[3] = '{4'd11, '0,        "addr11_zero"};
        vec[4] = '{4'd15, '0,        "addr15_zero"};
        vec[5] = '{4'd12, '0,        "addr12_zero"};
        vec[6] = '{4'd5,  '0,        "rk5_model"};

        rst_n = 1'b0; start = 1'b0; key_in = '0; rd_addr = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 128'(ifa.busy), 0);
        check("rst_done", 128'(ifa.done), 0);
        check("rst_kv", 128'(ifa.keys_valid), 0);
        check("rst_kg_key", ka_key, 0);
        check("rst_kg_rc", 128'(ka_rc), 0);
        check("rst_rd0", ifa.rk_rd_data, 0);
        rst_n = 1'b1;

        // Run 1: FIPS key, with an all-zero start 5 cycles in that must be ignored.
        build_model(FIPS_KEY);
        vec[6].exp = exp_rk[5];
        done_a = -1; done_b = -1; done_c = -1;
        ndone_a = 0; busy_a = 0; rc_bad = 0; kv_bad = 0;
        @(negedge clk); start = 1'b1; key_in = FIPS_KEY;
        @(posedge clk);
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c == 0) check("round0_kg_key", ka_key, FIPS_KEY);
            if (ifa.done) begin ndone_a++; if (done_a < 0) done_a = c; end
            if (ifb.done && done_b < 0) done_b = c;
            if (ifc.done && done_c < 0) done_c = c;
            if (ifa.busy) busy_a++;
            if (c < 20 && ka_rc != 4'(c / 2)) rc_bad++;
            if (ka_rc > 4'd9) rc_bad++;
            if (ifa.busy && ifa.keys_valid) kv_bad++;
            start = 1'b0;
            if (c == 4) begin start = 1'b1; key_in = '0; end
        end
        check("done_cycle_lat1", 128'(done_a), 20);
        check("done_count", 128'(ndone_a), 1);
        check("busy_cycles", 128'(busy_a), 21);
        check("rc_sequence_errs", 128'(rc_bad), 0);
        check("kv_during_busy", 128'(kv_bad), 0);
        check("done_cycle_lat0", 128'(done_b), 10);
        check("done_cycle_lat3", 128'(done_c), 40);
        check("kv_a", 128'(ifa.keys_valid), 1);
        check("kv_b", 128'(ifb.keys_valid), 1);
        check("kv_c", 128'(ifc.keys_valid), 1);

        for (int inst = 0; inst < 3; inst++) begin
            for (int i = 0; i < 7; i++) begin
                rd_addr = vec[i].addr;
                #1;
                check($sformatf("inst%0d_%s", inst, vec[i].name), rd_of(inst), vec[i].exp);
            end
            for (int a = 2; a < 10; a++) begin
                rd_addr = 4'(a);
                #1;
                check($sformatf("inst%0d_rk%0d", inst, a), rd_of(inst), exp_rk[a]);
            end
        end
        rd_addr = '0;

        // Run 2: accepted all-zero key; a start held during the done cycle is ignored.
        @(negedge clk); start = 1'b1; key_in = '0;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        check("kv_clears_on_start", 128'(ifa.keys_valid), 0);
        k = -1;
        for (int c = 1; c < 60 && k < 0; c++) begin
            @(negedge clk);
            if (ifa.done) begin
                k = c;
                start = 1'b1; key_in = FIPS_KEY;
            end
        end
        check("zero_done_cycle", 128'(k), 20);
        @(negedge clk); start = 1'b0;
        check("start_in_done_ignored", 128'(ifa.busy), 0);
        check("zero_kv", 128'(ifa.keys_valid), 1);
        rd_addr = 4'd10; #1;
        check("zero_rk10", ifa.rk_rd_data, ZERO_RK10);
        rd_addr = 4'd0; #1;
        check("zero_rk0", ifa.rk_rd_data, 0);
        repeat (50) @(negedge clk);

        // Run 3: reset during round 6, then a clean restart.
        @(negedge clk); start = 1'b1; key_in = FIPS_KEY;
        @(posedge clk);
        k = -1;
        for (int c = 0; c < 60 && k < 0; c++) begin
            @(negedge clk); start = 1'b0;
            if (ka_rc == 4'd6) k = c;
        end
        check("reach_round6", 128'(k), 12);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", 128'(ifa.busy), 0);
        check("midrst_done", 128'(ifa.done), 0);
        check("midrst_kv", 128'(ifa.keys_valid), 0);
        check("midrst_kg_key", ka_key, 0);
        check("midrst_kg_rc", 128'(ka_rc), 0);
        check("midrst_rd0", ifa.rk_rd_data, 0);
        rd_addr = 4'd3; #1;
        check("midrst_rd3", ifa.rk_rd_data, 0);
        k = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (ifa.done) k++;
        end
        rst_n = 1'b1;
        check("midrst_no_done", 128'(k), 0);
        run_a(FIPS_KEY, k);
        check("restart_done_cycle", 128'(k), 20);
        rd_addr = 4'd10; #1;
        check("restart_rk10", ifa.rk_rd_data, FIPS_RK10);
        check("restart_kv", 128'(ifa.keys_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
